seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the 4-bit counter stage and consumes its packed 16-bit count (four hex nibbles) through a load strobe. Captured values are applied only at frame boundaries, so the display never tears. The block rotates one digit per slot, inserts a dark guard interval at each digit switch to suppress ghosting, and pulses `frame_done` once per full scan.

---
 rtl/seg7_scan_driver_if.sv | 11 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Load-side bus of the seven-segment scan driver: the digit values, the blank and
// decimal-point masks, and the strobe that captures them.
interface seg7_scan_driver_if;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic        data_load;

    modport master (output data_in, blank_in, dp_in, data_load);
    modport slave  (input  data_in, blank_in, dp_in, data_load);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner. Loads are double-buffered and applied
// only at frame boundaries; each digit slot begins with a dark guard interval.
module seg7_scan_driver #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    ld,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;

    logic [3:0][3:0]  pend_data_q, pend_data_d;
    logic [3:0]       pend_blank_q, pend_blank_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_v_q, pend_v_d;

    logic [3:0][3:0]  act_data_q, act_data_d;
    logic [3:0]       act_blank_q, act_blank_d;
    logic [3:0]       act_dp_q, act_dp_d;

    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             boundary;
    logic             lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = slot_end && (sel_q == 2'd3);

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        sel_d = slot_end ? sel_q + 2'd1 : sel_q;
    end

    // Boundary transfer reads the old pending set, so a load on that very
    // cycle lands in pending and waits for the following boundary.
    always_comb begin
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_v_d     = pend_v_q;
        if (boundary && pend_v_q) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
            act_dp_d    = pend_dp_q;
            pend_v_d    = 1'b0;
        end
        if (ld.data_load) begin
            pend_data_d  = ld.data_in;
            pend_blank_d = ld.blank_in;
            pend_dp_d    = ld.dp_in;
            pend_v_d     = 1'b1;
        end
    end

    assign frame_done_d = boundary;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            pend_data_q  <= '0;
            pend_blank_q <= 4'h0;
            pend_dp_q    <= 4'h0;
            pend_v_q     <= 1'b0;
            act_data_q   <= '0;
            act_blank_q  <= 4'hF;
            act_dp_q     <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs depend on registers only, so nothing on the load bus can glitch them.
    assign lit = (cnt_q >= CNT_BLANK) && !act_blank_q[sel_q];

    always_comb begin
        an  = 4'b1111;
        seg = 7'h7F;
        dp  = 1'b1;
        if (lit) begin
            an  = ~(4'b0001 << sel_q);
            seg = hex7(act_data_q[sel_q]);
            dp  = ~act_dp_q[sel_q];
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-level model checked every cycle, plus directed
// literal expectations at hand-picked cycles.
module tb_seg7_scan_driver;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (bus.slave),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
    } ld_s;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int  t = 0;
    bit  synced = 1'b0;
    ld_s loads[$];
    int  total = 0;
    int  bad = 0;

    // t is the cycle index since the last reset; loads are stamped with the cycle they were sampled in.
    always @(posedge clk) begin
        if (!rst_n) begin
            t = 0;
            synced = 1'b1;
            loads.delete();
        end else if (synced) begin
            if (bus.data_load) begin
                ld_s e;
                e.t = t;
                e.d = bus.data_in;
                e.b = bus.blank_in;
                e.p = bus.dp_in;
                loads.push_back(e);
            end
            t++;
        end
    end

    // A load shows in frame F when it is the latest one sampled strictly before
    // the last cycle of frame F-1.
    task automatic model(input int tt, output logic [3:0] ean, output logic [6:0] eseg,
                         output logic edp, output logic efd);
        int  bnd;
        int  slot;
        int  c;
        int  idx;
        ld_s e;
        bnd  = (tt / FRAME) * FRAME - 1;
        slot = (tt % FRAME) / SLOT;
        c    = tt % SLOT;
        idx  = -1;
        foreach (loads[i]) if (loads[i].t < bnd) idx = i;
        efd  = (tt % FRAME == 0) && (tt >= FRAME);
        ean  = 4'hF;
        eseg = 7'h7F;
        edp  = 1'b1;
        if (idx >= 0) begin
            e = loads[idx];
            if (c >= BLANK && !e.b[slot]) begin
                ean[slot] = 1'b0;
                eseg = seg_tab[e.d[slot*4 +: 4]];
                edp  = ~e.p[slot];
            end
        end
    endtask

    always @(negedge clk) begin
        if (synced) begin
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            logic       ef;
            model(t, ea, es, ed, ef);
            total++;
            if ({an, seg, dp, frame_done} !== {ea, es, ed, ef}) begin
                bad++;
                $display("FAIL model t=%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                         t, an, seg, dp, frame_done, ea, es, ed, ef);
            end
        end
    end

    task automatic wait_t(input int n);
        int k = 0;
        while (t != n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (t != n) begin
            total++;
            bad++;
            $display("FAIL wait_t: reached t=%0d, want t=%0d", t, n);
        end
    endtask

    task automatic chk(input int n, input string nm, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef);
        wait_t(n);
        total++;
        if ({an, seg, dp, frame_done} !== {ea, es, ed, ef}) begin
            bad++;
            $display("FAIL %s t=%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                     nm, t, an, seg, dp, frame_done, ea, es, ed, ef);
        end
    endtask

    task automatic load_at(input int n, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        wait_t(n);
        bus.data_in   = d;
        bus.blank_in  = b;
        bus.dp_in     = p;
        bus.data_load = 1'b1;
        @(negedge clk);
        bus.data_load = 1'b0;
    endtask

    initial begin
        bus.data_in   = 16'h0;
        bus.blank_in  = 4'h0;
        bus.dp_in     = 4'h0;
        bus.data_load = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset: dark, frame pulse only on frame starts after the first
        chk(0,  "reset_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        chk(31, "idle_fd31",  4'hF, 7'h7F, 1'b1, 1'b0);
        chk(32, "idle_fd32",  4'hF, 7'h7F, 1'b1, 1'b1);
        chk(33, "idle_fd33",  4'hF, 7'h7F, 1'b1, 1'b0);
        chk(64, "idle_fd64",  4'hF, 7'h7F, 1'b1, 1'b1);

        // basic scan
        load_at(70, 16'h1234, 4'b0000, 4'b0100);
        chk(90,  "pre_bnd_dark", 4'hF,    7'h7F, 1'b1, 1'b0);
        chk(96,  "guard_d0",     4'hF,    7'h7F, 1'b1, 1'b1);
        chk(98,  "scan_d0",      4'b1110, 7'h19, 1'b1, 1'b0);
        chk(106, "scan_d1",      4'b1101, 7'h30, 1'b1, 1'b0);
        chk(114, "scan_d2_dp",   4'b1011, 7'h24, 1'b0, 1'b0);
        chk(122, "scan_d3",      4'b0111, 7'h79, 1'b1, 1'b0);

        // overwrite within one frame: last load wins
        load_at(130, 16'hAAAA, 4'b0000, 4'b0000);
        load_at(140, 16'hBEEF, 4'b0000, 4'b0000);
        chk(150, "hold_old",  4'b1011, 7'h24, 1'b0, 1'b0);
        chk(162, "beef_d0",   4'b1110, 7'h0E, 1'b1, 1'b0);
        chk(170, "beef_d1",   4'b1101, 7'h06, 1'b1, 1'b0);

        // load on the boundary cycle itself (sel=3, cnt=7)
        load_at(172, 16'h1111, 4'b0000, 4'b0000);
        load_at(191, 16'h2222, 4'b0000, 4'b0000);
        chk(194, "collide_old",    4'b1110, 7'h79, 1'b1, 1'b0);
        chk(218, "collide_old_d3", 4'b0111, 7'h79, 1'b1, 1'b0);
        chk(226, "collide_new",    4'b1110, 7'h24, 1'b1, 1'b0);

        // per-digit blanking
        load_at(230, 16'h00F0, 4'b1001, 4'b0000);
        chk(258, "mask_d0",     4'hF,    7'h7F, 1'b1, 1'b0);
        chk(263, "mask_d0_end", 4'hF,    7'h7F, 1'b1, 1'b0);
        chk(266, "mask_d1",     4'b1101, 7'h0E, 1'b1, 1'b0);
        chk(274, "mask_d2",     4'b1011, 7'h40, 1'b1, 1'b0);
        chk(282, "mask_d3",     4'hF,    7'h7F, 1'b1, 1'b0);

        // reset together with a load during slot 2
        wait_t(305);
        bus.data_in   = 16'h9999;
        bus.blank_in  = 4'h0;
        bus.dp_in     = 4'hF;
        bus.data_load = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (dut.cnt_q !== 3'd0 || dut.sel_q !== 2'd0) begin
            bad++;
            $display("FAIL rst_counters: got cnt=%0d sel=%0d, want cnt=0 sel=0", dut.cnt_q, dut.sel_q);
        end
        chk(0, "rst_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst_n = 1'b1;
        bus.data_load = 1'b0;
        chk(31, "post_rst_fd31", 4'hF, 7'h7F, 1'b1, 1'b0);
        chk(32, "post_rst_fd32", 4'hF, 7'h7F, 1'b1, 1'b1);
        chk(42, "post_rst_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        wait_t(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
